// File: rtl/freq_scaling_pkg.sv
// rtl/freq_scaling_pkg.sv - shared constants for the programmable frequency scaler
package freq_scaling_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_DIV   = 7;
    localparam int DEF_MODE  = 0;

endpackage

// File: rtl/freq_scaler_prog.sv
// rtl/freq_scaler_prog.sv - runtime-programmable tick and divided-clock generator
module freq_scaler_prog
    import freq_scaling_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_DIV  = DEF_DIV,
    parameter int DEFAULT_MODE = DEF_MODE
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             en,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
    input  logic             mode_wr,
    input  logic             mode_in,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             cfg_pending
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic             RST_MODE = (DEFAULT_MODE != 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_shadow;
    logic             mode_shadow;
    logic             mode_active;

    logic             terminal;
    logic             apply_now;
    logic             mode_change;
    logic [CNT_W-1:0] next_div;
    logic             next_mode;

    // Boundary detection and the configuration that would be applied this cycle.
    // A write in the applying cycle bypasses the shadow so it takes effect now.
    always_comb begin
        terminal    = 1'b0;
        apply_now   = 1'b0;
        mode_change = 1'b0;
        next_div    = div_shadow;
        next_mode   = mode_shadow;

        terminal  = en && (cnt == div_active);
        apply_now = !en || terminal;
        if (div_wr) begin
            next_div = div_in;
        end
        if (mode_wr) begin
            next_mode = mode_in;
        end
        mode_change = terminal && (next_mode != mode_active);
    end

    // Shadow capture and apply: active config only changes when the counter
    // restarts (boundary) or while stopped, so no runt period can appear.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            div_shadow  <= RST_DIV;
            mode_shadow <= RST_MODE;
            div_active  <= RST_DIV;
            mode_active <= RST_MODE;
            cfg_pending <= 1'b0;
        end else begin
            if (div_wr) begin
                div_shadow <= div_in;
            end
            if (mode_wr) begin
                mode_shadow <= mode_in;
            end
            if (apply_now) begin
                div_active  <= next_div;
                mode_active <= next_mode;
                cfg_pending <= 1'b0;
            end else if (div_wr || mode_wr) begin
                cfg_pending <= 1'b1;
            end
        end
    end

    // Period counter with registered tick and derived clock.
    // A mode change at the boundary restarts clk_out high in either mode.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (terminal) begin
            cnt  <= '0;
            tick <= 1'b1;
            if (mode_change || (next_mode == MODE_PULSE)) begin
                clk_out <= 1'b1;
            end else begin
                clk_out <= ~clk_out;
            end
        end else begin
            cnt  <= cnt + CNT_ONE;
            tick <= 1'b0;
            if (mode_active == MODE_PULSE) begin
                clk_out <= 1'b0;
            end
        end
    end

endmodule
